// File: rtl/spi_pkg.sv
// Shared SPI constants: byte width, default fill byte and mode-0 edge selection.
package spi_pkg;

  localparam int unsigned SPI_BYTE_W = 8;

  // Byte driven on MISO when the system has nothing queued at a byte boundary.
  localparam logic [SPI_BYTE_W-1:0] SPI_FILL_BYTE = 8'hFF;

  typedef enum logic {
    SpiEdgeRise = 1'b0,
    SpiEdgeFall = 1'b1
  } spi_edge_e;

  // Mode 0 (CPOL=0, CPHA=0): sample on sck rising, shift on sck falling.
  localparam spi_edge_e SPI_MODE0_SAMPLE_EDGE = SpiEdgeRise;
  localparam spi_edge_e SPI_MODE0_SHIFT_EDGE  = SpiEdgeFall;

endpackage

// File: rtl/sync_edge_det.sv
// N-stage synchroniser for an asynchronous input, with rise/fall pulses on the synced level.
module sync_edge_det #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Shift the pin through the synchroniser and remember the last synced level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign dout = chain[STAGES-1];
  assign rise = dout & ~prev;
  assign fall = ~dout & prev;

endmodule

// File: rtl/spi_byte_slave.sv
// SPI mode-0 byte responder: oversampled RX deserialiser and TX serialiser with a
// one-entry holding register and fill byte on underrun.
module spi_byte_slave
  import spi_pkg::*;
#(
  parameter logic [SPI_BYTE_W-1:0] FILL_BYTE   = SPI_FILL_BYTE,
  parameter int unsigned           SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sck,
  input  logic                  mosi,
  input  logic                  cs_n,
  output logic                  miso,
  output logic                  miso_oe,
  output logic [SPI_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  input  logic [SPI_BYTE_W-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic                  overrun
);

  localparam int unsigned CNT_W = $clog2(SPI_BYTE_W);

  logic sck_level_unused, sck_rise, sck_fall;
  logic mosi_sync, mosi_rise_unused, mosi_fall_unused;
  logic cs_sync, cs_rise_unused, cs_fall;

  logic [CNT_W-1:0]      bit_cnt;
  logic [SPI_BYTE_W-2:0] rx_shift;
  logic                  rx_done;
  logic                  reload_pend;
  logic [SPI_BYTE_W-1:0] tx_shift;
  logic [SPI_BYTE_W-1:0] tx_hold;

  logic sample_edge, shift_edge, tx_boundary;

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
    .clk   (clk),
    .reset (reset),
    .din   (sck),
    .dout  (sck_level_unused),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
    .clk   (clk),
    .reset (reset),
    .din   (mosi),
    .dout  (mosi_sync),
    .rise  (mosi_rise_unused),
    .fall  (mosi_fall_unused)
  );

  // cs_n idles deasserted so reset never fakes a frame start unless the pin is low.
  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk   (clk),
    .reset (reset),
    .din   (cs_n),
    .dout  (cs_sync),
    .rise  (cs_rise_unused),
    .fall  (cs_fall)
  );

  assign sample_edge = (SPI_MODE0_SAMPLE_EDGE == SpiEdgeRise) ? sck_rise : sck_fall;
  assign shift_edge  = (SPI_MODE0_SHIFT_EDGE == SpiEdgeFall) ? sck_fall : sck_rise;

  // Byte boundary: frame start, or the shift edge that follows the 8th sample edge.
  assign tx_boundary = cs_fall | (shift_edge & ~cs_sync & reload_pend);

  assign miso    = tx_shift[SPI_BYTE_W-1];
  assign miso_oe = ~cs_sync;

  // RX: deserialise on sample edges; a deselect drops any partial byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt     <= '0;
      rx_shift    <= '0;
      rx_data     <= '0;
      rx_done     <= 1'b0;
      rx_valid    <= 1'b0;
      reload_pend <= 1'b0;
    end else begin
      rx_valid <= rx_done;
      rx_done  <= 1'b0;
      if (cs_sync) begin
        bit_cnt     <= '0;
        reload_pend <= 1'b0;
      end else if (sample_edge) begin
        rx_shift <= {rx_shift[SPI_BYTE_W-3:0], mosi_sync};
        bit_cnt  <= bit_cnt + CNT_W'(1);
        if (bit_cnt == CNT_W'(SPI_BYTE_W - 1)) begin
          rx_data     <= {rx_shift, mosi_sync};
          rx_done     <= 1'b1;
          reload_pend <= 1'b1;
        end
      end else if (shift_edge) begin
        reload_pend <= 1'b0;
      end
    end
  end

  // TX: reload at byte boundaries, shift on shift edges, manage the holding register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_shift <= FILL_BYTE;
      tx_hold  <= '0;
      tx_ready <= 1'b1;
      overrun  <= 1'b0;
    end else begin
      if (tx_boundary) begin
        if (!tx_ready) begin
          tx_shift <= tx_hold;
          tx_ready <= 1'b1;
        end else if (tx_load) begin
          // Empty holder and a same-cycle strobe: bypass straight to the shifter.
          tx_shift <= tx_data;
        end else begin
          tx_shift <= FILL_BYTE;
        end
      end else if (shift_edge && !cs_sync) begin
        tx_shift <= {tx_shift[SPI_BYTE_W-2:0], FILL_BYTE[0]};
      end

      if (tx_load) begin
        if (!tx_ready) begin
          overrun <= 1'b1;
        end else if (!tx_boundary) begin
          tx_hold  <= tx_data;
          tx_ready <= 1'b0;
        end
      end
    end
  end

endmodule
